// File: rtl/tt_um_hoene_rgb_frame_decoder_pkg.sv
// Shared definitions for the RGB frame decoder: FSM state encoding,
// default frame parameters and the serial CRC-8 step function.
package tt_um_hoene_rgb_frame_decoder_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CRC     = 2'd2
  } state_e;

  localparam logic [7:0] DEF_SYNC_WORD      = 8'hD5;
  localparam int         DEF_SYNC_LEN       = 8;
  localparam int         DEF_CHANNEL_W      = 10;
  localparam int         DEF_TIMEOUT_CYCLES = 4096;
  localparam int         PAYLOAD_BITS       = 30;
  localparam int         CRC_W              = 8;
  localparam logic [7:0] CRC_POLY           = 8'h07;

  // One MSB-first shift of the CRC-8 register for a single input bit.
  function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc, input logic bit_i);
    crc8_step = {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ bit_i) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/tt_um_hoene_rgb_frame_decoder_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00) with bit-enable and clear.
// Only built when HOENE_FRAME_CRC_EN is defined.
`ifdef HOENE_FRAME_CRC_EN
module tt_um_hoene_crc8
  import tt_um_hoene_rgb_frame_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q;

  // Accumulate one bit per enable; clear restarts the checksum.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc8_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule
`endif

// File: rtl/tt_um_hoene_rgb_frame_decoder.sv
// RGB frame decoder: hunts for the sync word in the recovered bit stream,
// deserialises a 3-channel payload and commits it only for complete,
// error-free frames. Optional trailing CRC-8 check: HOENE_FRAME_CRC_EN.
//
//  state      | meaning
//  -----------+----------------------------------------------
//  ST_HUNT    | shifting bits into sync register, waiting for sync word
//  ST_PAYLOAD | collecting the 3*CHANNEL_W payload bits
//  ST_CRC     | collecting the 8 CRC bits (CRC build only)
module tt_um_hoene_rgb_frame_decoder
  import tt_um_hoene_rgb_frame_decoder_pkg::*;
#(
  parameter int                  SYNC_LEN       = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD      = DEF_SYNC_WORD,
  parameter int                  CHANNEL_W      = DEF_CHANNEL_W,
  parameter int                  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_data,
  input  logic                 in_clk,
  input  logic                 in_error,
  output logic [CHANNEL_W-1:0] red,
  output logic [CHANNEL_W-1:0] green,
  output logic [CHANNEL_W-1:0] blue,
  output logic                 frame_valid,
  output logic                 insync,
  output logic                 frame_error
);

  localparam int PB    = 3 * CHANNEL_W;
  localparam int CNT_W = $clog2(PB);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                 state_q;
  logic                   in_clk_q;
  logic [SYNC_LEN-1:0]    sync_q;
  logic [PB-1:0]          shift_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   commit_q;
  logic [CHANNEL_W-1:0]   red_q, green_q, blue_q;
  logic                   frame_valid_q, insync_q, frame_error_q;

  logic                   strobe;
  logic                   abort;
  logic [SYNC_LEN-1:0]    sync_d;

  assign strobe = in_clk & ~in_clk_q;
  assign sync_d = {sync_q[SYNC_LEN-2:0], in_data};
  // An idle cycle that would be the TIMEOUT_CYCLES-th in a row ends the frame.
  assign abort  = in_error | (~strobe & (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)));

`ifdef HOENE_FRAME_CRC_EN
  logic [CRC_W-1:0] crc_rx_q;
  logic [CRC_W-1:0] crc_rx_d;
  logic [CRC_W-1:0] crc_calc;

  assign crc_rx_d = {crc_rx_q[CRC_W-2:0], in_data};

  tt_um_hoene_crc8 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_HUNT),
    .en_i  ((state_q == ST_PAYLOAD) && strobe),
    .bit_i (in_data),
    .crc_o (crc_calc)
  );
`endif

  // Frame FSM, counters and registered outputs. Commit is staged through
  // commit_q so outputs update one cycle after the final-bit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_HUNT;
      in_clk_q      <= 1'b0;
      sync_q        <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      commit_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_valid_q <= 1'b0;
      insync_q      <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef HOENE_FRAME_CRC_EN
      crc_rx_q      <= '0;
`endif
    end else begin
      in_clk_q      <= in_clk;
      commit_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;

      if (commit_q) begin
        red_q         <= shift_q[PB-1 -: CHANNEL_W];
        green_q       <= shift_q[2*CHANNEL_W-1 -: CHANNEL_W];
        blue_q        <= shift_q[CHANNEL_W-1:0];
        frame_valid_q <= 1'b1;
        insync_q      <= 1'b1;
      end

      if (state_q == ST_HUNT || strobe) begin
        tmo_q <= '0;
      end else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) begin
        tmo_q <= tmo_q + 1'b1;
      end

      case (state_q)
        ST_HUNT: begin
          if (in_error) begin
            sync_q   <= '0;
            insync_q <= 1'b0;
          end else if (strobe) begin
            if (sync_d == SYNC_WORD) begin
              sync_q  <= '0;
              cnt_q   <= '0;
              state_q <= ST_PAYLOAD;
            end else begin
              sync_q <= sync_d;
            end
          end
        end
        default: begin
          if (abort) begin
            state_q       <= ST_HUNT;
            sync_q        <= '0;
            frame_error_q <= 1'b1;
            insync_q      <= 1'b0;
          end else if (strobe) begin
            cnt_q <= cnt_q + 1'b1;
            if (state_q == ST_PAYLOAD) begin
              shift_q <= {shift_q[PB-2:0], in_data};
              if (cnt_q == CNT_W'(PB - 1)) begin
                cnt_q <= '0;
`ifdef HOENE_FRAME_CRC_EN
                state_q <= ST_CRC;
`else
                state_q  <= ST_HUNT;
                commit_q <= 1'b1;
`endif
              end
            end
`ifdef HOENE_FRAME_CRC_EN
            else begin
              crc_rx_q <= crc_rx_d;
              if (cnt_q == CNT_W'(CRC_W - 1)) begin
                cnt_q   <= '0;
                state_q <= ST_HUNT;
                if (crc_rx_d == crc_calc) begin
                  commit_q <= 1'b1;
                end else begin
                  frame_error_q <= 1'b1;
                  insync_q      <= 1'b0;
                end
              end
            end
`endif
          end
        end
      endcase
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_valid = frame_valid_q;
  assign insync      = insync_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_tt_um_hoene_rgb_frame_decoder.sv
// Self-checking bench for the RGB frame decoder (default and
// HOENE_FRAME_CRC_EN builds).
module tb_tt_um_hoene_rgb_frame_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_data;
  logic       in_clk;
  logic       in_error;
  logic [9:0] red, green, blue;
  logic       frame_valid, insync, frame_error;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0, fe_cnt = 0, both_cnt = 0, long_cnt = 0;
  logic fv_prev = 1'b0, fe_prev = 1'b0;

`ifdef HOENE_FRAME_CRC_EN
  localparam int FB = 38;
`else
  localparam int FB = 30;
`endif

  typedef struct {
    logic [9:0] r, g, b;
    logic [9:0] exp_r, exp_g, exp_b;
    int         exp_fv;
  } vec_t;

  vec_t tbl[4];

  tt_um_hoene_rgb_frame_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_clk      (in_clk),
    .in_error    (in_error),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_valid (frame_valid),
    .insync      (insync),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts pulses, overlaps and pulses longer than 1 cycle.
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
    if (frame_valid && frame_error) both_cnt++;
    if ((frame_valid && fv_prev) || (frame_error && fe_prev)) long_cnt++;
    fv_prev = frame_valid;
    fe_prev = frame_error;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input logic err);
    in_data  = b;
    in_error = err;
    in_clk   = 1'b1;
    tick(); tick();
    in_clk   = 1'b0;
    tick();
    in_error = 1'b0;
    tick();
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

`ifdef HOENE_FRAME_CRC_EN
  function automatic logic [7:0] crc8(input logic [29:0] d);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 29; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
`endif

  // Sync word, then the first nsend frame bits; optional error / flipped bit
  // at a given index and an idle gap after a given index.
  task automatic send_frame(input logic [29:0] pl, input int nsend, input int err_at,
                            input int flip_at, input int gap_at, input int gap_len);
    logic [37:0] fr;
    logic        b;
    fr = {pl, 8'h00};
`ifdef HOENE_FRAME_CRC_EN
    fr[7:0] = crc8(pl);
`endif
    send_bits(64'hD5, 8);
    for (int i = 0; i < nsend; i++) begin
      b = fr[37 - i];
      if (i == flip_at) b = ~b;
      send_bit(b, i == err_at);
      if (i == gap_at) idle(gap_len);
    end
  endtask

  task automatic expect_commit(input string name, input logic [9:0] r, input logic [9:0] g,
                               input logic [9:0] b, input int fv0, input int fe0);
    idle(4);
    check({name, "_fv"}, fv_cnt - fv0, 1);
    check({name, "_fe"}, fe_cnt - fe0, 0);
    check({name, "_red"}, red, r);
    check({name, "_green"}, green, g);
    check({name, "_blue"}, blue, b);
    check({name, "_insync"}, insync, 1);
  endtask

  initial begin
    int fv0, fe0, waited;

    tbl[0] = '{10'h3FF, 10'h000, 10'h155, 10'h3FF, 10'h000, 10'h155, 1};
    tbl[1] = '{10'h000, 10'h3FF, 10'h2AA, 10'h000, 10'h3FF, 10'h2AA, 1};
    tbl[2] = '{10'h155, 10'h2AA, 10'h001, 10'h155, 10'h2AA, 10'h001, 1};
    tbl[3] = '{10'h200, 10'h001, 10'h3FE, 10'h200, 10'h001, 10'h3FE, 1};

    rst = 1'b1; in_data = 1'b0; in_clk = 1'b0; in_error = 1'b0;
    tick(); tick();
    rst = 1'b0;
    idle(10);
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_insync", insync, 0);
    check("rst_pulses", fv_cnt + fe_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      fv0 = fv_cnt; fe0 = fe_cnt;
      send_frame({tbl[i].r, tbl[i].g, tbl[i].b}, FB, -1, -1, -1, 0);
      idle(4);
      check("tbl_fv", fv_cnt - fv0, tbl[i].exp_fv);
      check("tbl_fe", fe_cnt - fe0, 0);
      check("tbl_red", red, tbl[i].exp_r);
      check("tbl_green", green, tbl[i].exp_g);
      check("tbl_blue", blue, tbl[i].exp_b);
      check("tbl_insync", insync, 1);
    end

    // Coding error on payload bit 12 abandons the frame; outputs hold.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h0AA, 10'h0BB, 10'h0CC}, 12, 11, -1, -1, 0);
    idle(4);
    check("err12_fe", fe_cnt - fe0, 1);
    check("err12_fv", fv_cnt - fv0, 0);
    check("err12_insync", insync, 0);
    check("err12_red", red, 10'h200);
    check("err12_blue", blue, 10'h3FE);
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h3FF, 10'h000, 10'h155}, FB, -1, -1, -1, 0);
    expect_commit("err12_rec", 10'h3FF, 10'h000, 10'h155, fv0, fe0);

    // Strobes stop after 20 payload bits: timeout abandons the frame.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h111, 10'h222, 10'h333}, 20, -1, -1, -1, 0);
    waited = 0;
    while (fe_cnt == fe0 && waited < 5000) begin
      tick();
      waited++;
    end
    check("tmo_fe", fe_cnt - fe0, 1);
    check("tmo_window", (waited >= 4080 && waited <= 4100) ? 1 : 0, 1);
    check("tmo_insync", insync, 0);
    check("tmo_red", red, 10'h3FF);
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h123, 10'h045, 10'h3C0}, FB, -1, -1, -1, 0);
    expect_commit("tmo_rec", 10'h123, 10'h045, 10'h3C0, fv0, fe0);

    // A 4000-cycle gap stays under the timeout; the frame still commits.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h0F0, 10'h30F, 10'h00F}, FB, -1, -1, 19, 4000);
    expect_commit("gap", 10'h0F0, 10'h30F, 10'h00F, fv0, fe0);

    // Error on the very last frame bit wins over the commit.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h001, 10'h002, 10'h003}, FB, FB - 1, -1, -1, 0);
    idle(4);
    check("last_err_fe", fe_cnt - fe0, 1);
    check("last_err_fv", fv_cnt - fv0, 0);
    check("last_err_green", green, 10'h30F);

`ifdef HOENE_FRAME_CRC_EN
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h155, 10'h155, 10'h155}, FB, -1, 33, -1, 0);
    idle(4);
    check("crc_bad_fe", fe_cnt - fe0, 1);
    check("crc_bad_fv", fv_cnt - fv0, 0);
    check("crc_bad_red", red, 10'h0F0);
    check("crc_bad_insync", insync, 0);
`endif

    // Sync preceded by noise 110101: lock only on the true D5 alignment.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_bits(64'b110101, 6);
    send_frame({10'h2AA, 10'h155, 10'h0F0}, FB, -1, -1, -1, 0);
    expect_commit("overlap", 10'h2AA, 10'h155, 10'h0F0, fv0, fe0);

    // in_error while hunting clears the partial sync match and insync.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_bits(64'b1101010, 7);
    in_error = 1'b1;
    tick(); tick();
    in_error = 1'b0;
    tick();
    send_bit(1'b1, 1'b0);
    send_bits(64'h0, 30);
    send_bits(64'h0, FB - 30);
    idle(4);
    check("hunt_err_insync", insync, 0);
    check("hunt_err_fv", fv_cnt - fv0, 0);
    check("hunt_err_fe", fe_cnt - fe0, 0);

    // Reset mid-payload: everything back to reset values, no pulses.
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame(30'h0, 15, -1, -1, -1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send_bits(64'h0, FB - 15);
    idle(4);
    check("midrst_red", red, 0);
    check("midrst_blue", blue, 0);
    check("midrst_insync", insync, 0);
    check("midrst_fv", fv_cnt - fv0, 0);
    check("midrst_fe", fe_cnt - fe0, 0);
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_frame({10'h3C3, 10'h03C, 10'h281}, FB, -1, -1, -1, 0);
    expect_commit("midrst_rec", 10'h3C3, 10'h03C, 10'h281, fv0, fe0);

    check("pulse_overlap", both_cnt, 0);
    check("pulse_width", long_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
